// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake bundle between the operand source and alu_seq.
//   in_valid/in_ready : operation offer / accept
//   op, a, b, shamt   : operation code, operands, shift amount
//   out_valid/out_ready : result offer / consume
//   out, flags        : registered result and {N,Z,C,V}
interface alu_seq_if #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, a, b, shamt, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, op, a, b, shamt, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and N/Z/C/V flags.
// Shifts run one bit per cycle using the result register as working storage.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : alu_seq_if slave (operation in, result out)
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_NEG = 3'd2,
    OP_AND = 3'd3,
    OP_ORR = 3'd4,
    OP_EOR = 3'd5,
    OP_LSL = 3'd6,
    OP_LSR = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           r_state, w_state_d;
  logic [SHW-1:0]   r_cnt, w_cnt_d;
  logic             r_lsl, w_lsl_d;
  logic [WIDTH-1:0] r_out, w_out_d;
  logic [3:0]       r_flags, w_flags_d;
  logic             r_out_valid, w_out_valid_d;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_done;

  assign w_in_ready = !rst && (r_state == IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.flags     = r_flags;

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_lsl_d       = r_lsl;
    w_out_d       = r_out;
    w_flags_d     = r_flags;
    w_out_valid_d = r_out_valid && !bus.out_ready;
    w_ext         = '0;
    w_res         = '0;
    w_c           = 1'b0;
    w_v           = 1'b0;
    w_done        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (op_e'(bus.op))
            OP_ADD: begin
              w_ext  = {1'b0, bus.a} + {1'b0, bus.b};
              w_res  = w_ext[WIDTH-1:0];
              w_c    = w_ext[WIDTH];
              w_v    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_res[WIDTH-1] != bus.a[WIDTH-1]);
              w_done = 1'b1;
            end
            OP_SUB: begin
              // Carry is NOT borrow: set when a >= b unsigned.
              w_ext  = {1'b0, bus.a} - {1'b0, bus.b};
              w_res  = w_ext[WIDTH-1:0];
              w_c    = ~w_ext[WIDTH];
              w_v    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_res[WIDTH-1] != bus.a[WIDTH-1]);
              w_done = 1'b1;
            end
            OP_NEG: begin w_res = ~bus.b;         w_done = 1'b1; end
            OP_AND: begin w_res = bus.a & bus.b;  w_done = 1'b1; end
            OP_ORR: begin w_res = bus.a | bus.b;  w_done = 1'b1; end
            OP_EOR: begin w_res = bus.a ^ bus.b;  w_done = 1'b1; end
            OP_LSL, OP_LSR: begin
              w_res = bus.a;
              if (bus.shamt == '0) begin
                w_done = 1'b1;
              end else begin
                // Load the working register; flags stay put until the last step.
                w_out_d       = bus.a;
                w_cnt_d       = bus.shamt;
                w_lsl_d       = (op_e'(bus.op) == OP_LSL);
                w_state_d     = SHIFT;
                w_out_valid_d = 1'b0;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        if (r_lsl) begin
          w_res = r_out << 1;
          w_c   = r_out[WIDTH-1];
        end else begin
          w_res = r_out >> 1;
          w_c   = r_out[0];
        end
        w_out_d = w_res;
        w_cnt_d = r_cnt - 1'b1;
        if (r_cnt == SHW'(1)) begin
          w_done    = 1'b1;
          w_state_d = IDLE;
        end
      end
    endcase

    if (w_done) begin
      w_out_d       = w_res;
      w_flags_d     = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
      w_out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_lsl       <= 1'b0;
      r_out       <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_lsl       <= w_lsl_d;
      r_out       <= w_out_d;
      r_flags     <= w_flags_d;
      r_out_valid <= w_out_valid_d;
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit ALU. It has operand width `WIDTH`, valid/ready flow control on input and output, and a registered result with fully computed N/Z/C/V flags. Shifts run iteratively, one bit position per cycle, under a small state machine. The block sits between the register-file read stage and writeback, and stalls upstream through `in_ready` while a shift is in progress or a result is unconsumed.

## Interface
- `WIDTH`, default 8: operand/result width; power of two, ≥ 2.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width; derived, not overridden.

Ports:
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: operation offered.
- `in_ready`  output  1: block can accept an operation this cycle.
- `op`  input  3: operation code (see Operation).
- `a`  input  WIDTH: first operand; also the shift source.
- `b`  input  WIDTH: second operand.
- `shamt`  input  SHW: shift amount, 0..WIDTH-1.
- `out_valid`  output  1: `out`/`flags` hold a new result.
- `out_ready`  input  1: consumer takes the result.
- `out`  output  WIDTH: registered result.
- `flags`  output  4: registered flags {N, Z, C, V} in bits [3:0].

## Operation
- **Op codes:**
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 NEG: ~b
  - 3 AND
  - 4 ORR
  - 5 EOR
  - 6 LSL: a<<shamt
  - 7 LSR: a>>shamt, logical
  - All ops are defined; there is no hold/default op.
- **Accept:** an operation is accepted on the rising edge where `in_valid && in_ready`. Operands are sampled only at that edge.
- **`in_ready`:** `in_ready = !rst && state==IDLE && (!out_valid || out_ready)`.
- **States:** IDLE, SHIFT.
  - IDLE → SHIFT on accept of LSL/LSR with `shamt`≠0.
  - SHIFT → IDLE on the edge where the remaining count reaches 0.
  - All other accepts stay in IDLE.
- **Arithmetic:** computed at WIDTH+1 bits.
  - ADD: C = carry out.
  - SUB: C = NOT borrow (ARM convention), so C=1 when a ≥ b unsigned.
  - V = signed overflow for ADD/SUB.
- **Logic ops (NEG/AND/ORR/EOR):** C=0, V=0.
- **Shifts:**
  - C = last bit shifted out; C=0 when `shamt`=0.
  - V=0.
  - Shifting uses `out` as the working register.
- **N and Z, all ops:** N = `out[WIDTH-1]`; Z = (`out`==0). Both are evaluated on the final result.
- **Flag timing:** `flags` change only on the edge that sets `out_valid`. They do not change on intermediate shift steps.
- **`out_valid`:**
  - Set on result completion.
  - Cleared on an edge where `out_valid && out_ready` and no new result completes.
  - `out` and `flags` are stable while `out_valid && !out_ready`.

## Timing
- **Reset values:**
  - `out`=0, `flags`=0, `out_valid`=0, state IDLE, shift count 0.
  - `in_ready`=0 while `rst` is high.
- **Latency, non-shift ops and shifts with `shamt`=0:** 1 cycle. `out_valid` is high in the cycle after the accept edge.
- **Latency, shifts with `shamt`=k>0:**
  - Accept edge loads `out`←`a`, count←k, state SHIFT, `out_valid`←0.
  - Each following edge shifts by 1 and decrements the count.
  - The edge that decrements 1→0 sets `out_valid` and `flags` and returns to IDLE.
  - Total latency is k+1 cycles; `in_ready`=0 throughout SHIFT.
- **Throughput:** one op per cycle for non-shift ops when `out_ready`=1. Back-to-back accepts are allowed in the same cycle the previous result is consumed.
- **Simultaneous consume and accept:** `out_valid` stays 1 and `out`/`flags` take the new result.
- **Backpressure:** with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and `in_valid` is ignored.
- **Reset mid-shift:** the shift is aborted. All state takes reset values on that edge, and no partial result is ever flagged valid.
- **Out-of-range `shamt`:** cannot occur; SHW bits cover 0..WIDTH-1 exactly.

## Test plan
- **Reset:** hold `rst` 2 cycles with `in_valid`=1 → `in_ready`=0, `out`=0x00, `flags`=0, `out_valid`=0 throughout.
- **ADD overflow, WIDTH=8:** a=0x7F, b=0x01 → 1 cycle later `out`=0x80, `flags`=N1 Z0 C0 V1 (0b1001).
- **SUB equal:** a=0x05, b=0x05 → `out`=0x00, `flags`=0b0110 (Z, C).
- **LSR multi-cycle:** a=0xB4, `shamt`=3 → `in_ready`=0 for 3 cycles. `out_valid` rises 4 cycles after accept with `out`=0x16, `flags`=0b0010 (C).
- **Backpressure:** hold `out_ready`=0 after an EOR of 0xF0^0xFF, with a second ADD offered:
  - `out`=0x0F held and `in_ready`=0.
  - Raising `out_ready` accepts the ADD on the same edge; its result appears the next cycle.
- **Reset mid-shift:** LSL a=0x01, `shamt`=7, assert `rst` at step 3 → after the reset edge `out`=0, `out_valid`=0. A subsequent ADD 0x02+0x03 returns 0x05 with `flags`=0.
